i2c_host_fifo: RTL and testbench
================================

Name: i2c_host_fifo

Overview:
- CPU-side buffering front end that sits directly upstream of the I2C transceiver.
- Generates the transceiver's I2C_CLK tick enable from CLK using a programmable divider.
- Holds a TX byte FIFO that feeds I2C_TxDATA through the XRDY/XRDY_CLR handshake.
- Holds an RX byte FIFO that drains I2C_RxDATA through the RRDY/RRDY_CLR handshake, so software can run multi-byte transfers without per-byte servicing.

Parameters:
- DEPTH, 16, entries per FIFO; power of 2, minimum 2.
- LW, $clog2(DEPTH)+1, width of the level outputs (derived).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset; synchronous, active-high.
- CLKDIV  in  16  tick divider; one I2C_CLK tick every CLKDIV+1 cycles.
- FLUSH  in  1  clears both FIFOs and both handshake FSMs.
- TX_WR  in  1  push TX_WDATA into the TX FIFO.
- TX_WDATA  in  8  byte to transmit.
- TX_FULL  out  1  TX FIFO full.
- TX_LEVEL  out  LW  TX FIFO occupancy.
- RX_RD  in  1  pop the RX FIFO.
- RX_RDATA  out  8  RX FIFO head (first-word fall-through).
- RX_EMPTY  out  1  RX FIFO empty.
- RX_LEVEL  out  LW  RX FIFO occupancy.
- I2C_CLK  out  1  one-CLK-wide tick enable to the transceiver.
- I2C_TxDATA  out  8  TX FIFO head.
- I2C_XRDY  in  1  transceiver requests a TX byte.
- I2C_XRDY_CLR  out  1  TX byte supplied.
- I2C_RxDATA  in  8  received byte.
- I2C_RRDY  in  1  received byte available.
- I2C_RRDY_CLR  out  1  received byte taken.
- I2C_NACK  in  1  sticky NACK from the transceiver.
- ERR_CLR  in  1  clears error flags.
- ERR_FLAGS  out  2  [0] TX overflow, [1] RX underflow.
- IRQ  out  1  interrupt request.

Behaviour:
- Reset (RESET high at a CLK edge): all outputs 0 except RX_EMPTY=1; the divider counter is 0; both FSMs are idle; FIFO contents are don't-care.
- Divider: counter counts 0..CLKDIV. I2C_CLK is a registered output, high for exactly one cycle when counter==CLKDIV; the counter then returns to 0.
  - The compare is counter>=CLKDIV, so lowering CLKDIV mid-count wraps on the next cycle.
  - CLKDIV=0 gives I2C_CLK high every cycle.
- TX FIFO:
  - A push is accepted iff TX_WR=1 and TX_FULL=0 at that edge; a write while full is dropped.
  - I2C_TxDATA is the head entry, combinational from memory; it is 0 when empty.
  - A push and a pop in the same cycle leave the level unchanged.
- RX FIFO:
  - A pop is accepted iff RX_RD=1 and RX_EMPTY=0; a read while empty is ignored and RX_RDATA holds.
  - A push and a pop in the same cycle are both honoured.
- Pointers wrap modulo DEPTH; the level counter saturates at neither end because overflow and underflow are blocked.
- TX FSM (all state evaluation happens only on I2C_CLK cycles):
  - T_IDLE: if I2C_XRDY=1 and the TX FIFO is not empty, set I2C_XRDY_CLR=1 and go to T_PRESENT.
  - T_PRESENT: clear I2C_XRDY_CLR, pop the TX FIFO, go to T_WAIT. I2C_XRDY_CLR is therefore high for exactly one tick period, and the head is stable throughout.
  - T_WAIT: when I2C_XRDY=0, go to T_IDLE; this prevents a double supply.
- RX FSM (same tick qualification):
  - R_IDLE: if I2C_RRDY=1 and the RX FIFO is not full, push I2C_RxDATA and set I2C_RRDY_CLR=1, then go to R_ACK.
  - R_ACK: clear I2C_RRDY_CLR, go to R_WAIT.
  - R_WAIT: when I2C_RRDY=0, go to R_IDLE.
  - A full RX FIFO stalls in R_IDLE (backpressure); no data is lost.
- FLUSH (one cycle) has priority over push, pop and FSM activity:
  - Empties both FIFOs.
  - Forces both FSMs to idle and drives both CLR outputs to 0 on the next edge.
  - The divider is unaffected.
- RESET has priority over FLUSH. Reset mid-handshake drops CLR immediately at that edge.

Optional Feature:
- Macro I2C_HOST_FIFO_IRQ_EN.
- Defined:
  - ERR_FLAGS[0] is set sticky when a TX write is dropped.
  - ERR_FLAGS[1] is set sticky when an RX read hits empty.
  - ERR_CLR=1 clears both flags; a simultaneous set wins.
  - IRQ is registered, equal to (TX FIFO empty) | ~RX_EMPTY | I2C_NACK | (|ERR_FLAGS).
- Undefined: ERR_FLAGS=0 and IRQ=0 constantly; ERR_CLR is ignored.

Test Plan:
- CLKDIV=3 after reset -> I2C_CLK pulses every 4 cycles. Change CLKDIV to 1 while the counter is at 2 -> next pulse occurs 1 cycle later, then every 2 cycles.
- Push 0xA5, 0x3C; model raises I2C_XRDY -> I2C_TxDATA=0xA5 while I2C_XRDY_CLR is high for one tick. With I2C_XRDY held high, no second CLR occurs. After the model drops I2C_XRDY and re-raises it -> 0x3C is supplied; TX_LEVEL goes 2->1->0.
- Push DEPTH+1 bytes -> TX_FULL=1 and TX_LEVEL=DEPTH; the last byte is dropped. With the IRQ macro, ERR_FLAGS=2'b01 and IRQ=1; ERR_CLR -> 2'b00.
- Model delivers DEPTH+1 bytes via I2C_RRDY -> RX fills and the last RRDY stays un-cleared. One RX_RD -> that byte is accepted on the next tick. Read order matches delivery.
- FLUSH asserted while in T_PRESENT with 3 bytes queued -> I2C_XRDY_CLR=0 next cycle, TX_LEVEL=0, RX_EMPTY=1.
- RESET asserted mid-RX handshake -> all outputs return to reset values at that edge; a subsequent transfer works normally.

Source files
------------

// File: rtl/i2c_host_fifo.sv
// CPU-side TX/RX byte FIFOs and tick divider in front of the I2C transceiver.
// Optional error flags and interrupt: define I2C_HOST_FIFO_IRQ_EN.
module i2c_host_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [15:0]   CLKDIV,
    input  logic          FLUSH,
    input  logic          TX_WR,
    input  logic [7:0]    TX_WDATA,
    output logic          TX_FULL,
    output logic [LW-1:0] TX_LEVEL,
    input  logic          RX_RD,
    output logic [7:0]    RX_RDATA,
    output logic          RX_EMPTY,
    output logic [LW-1:0] RX_LEVEL,
    output logic          I2C_CLK,
    output logic [7:0]    I2C_TxDATA,
    input  logic          I2C_XRDY,
    output logic          I2C_XRDY_CLR,
    input  logic [7:0]    I2C_RxDATA,
    input  logic          I2C_RRDY,
    output logic          I2C_RRDY_CLR,
    input  logic          I2C_NACK,
    input  logic          ERR_CLR,
    output logic [1:0]    ERR_FLAGS,
    output logic          IRQ
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_PRESENT, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;

    logic [15:0]   cnt_q, cnt_d;
    logic          tick_q, tick_d;
    tx_state_t     tx_state_q, tx_state_d;
    rx_state_t     rx_state_q, rx_state_d;
    logic          xrdy_clr_q, xrdy_clr_d;
    logic          rrdy_clr_q, rrdy_clr_d;
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [LW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]    rx_rdata_q, rx_rdata_d;
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_LVL);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_LVL);

    // FLUSH suppresses every FIFO transfer in its cycle
    assign tx_push = TX_WR & ~tx_full & ~FLUSH;
    assign tx_pop  = tick_q & (tx_state_q == T_PRESENT) & ~FLUSH;
    assign rx_push = tick_q & (rx_state_q == R_IDLE) & I2C_RRDY & ~rx_full & ~FLUSH;
    assign rx_pop  = RX_RD & ~rx_empty & ~FLUSH;

    // Greater-or-equal compare lets a lowered CLKDIV wrap immediately
    always_comb begin
        cnt_d  = cnt_q + 16'd1;
        tick_d = 1'b0;
        if (cnt_q >= CLKDIV) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_comb begin
        tx_wp_d    = tx_push ? tx_wp_q + AW'(1) : tx_wp_q;
        tx_rp_d    = tx_pop  ? tx_rp_q + AW'(1) : tx_rp_q;
        tx_cnt_d   = tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
        rx_wp_d    = rx_push ? rx_wp_q + AW'(1) : rx_wp_q;
        rx_rp_d    = rx_pop  ? rx_rp_q + AW'(1) : rx_rp_q;
        rx_cnt_d   = rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
        rx_rdata_d = rx_rdata_q;
        // Next head may be the byte being written this very cycle
        if (rx_cnt_d != '0) begin
            rx_rdata_d = (rx_push && (rx_rp_d == rx_wp_q)) ? I2C_RxDATA : rx_mem_q[rx_rp_d];
        end
        if (FLUSH) begin
            tx_wp_d    = '0;
            tx_rp_d    = '0;
            tx_cnt_d   = '0;
            rx_wp_d    = '0;
            rx_rp_d    = '0;
            rx_cnt_d   = '0;
            rx_rdata_d = '0;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        xrdy_clr_d = xrdy_clr_q;
        rx_state_d = rx_state_q;
        rrdy_clr_d = rrdy_clr_q;
        if (tick_q) begin
            case (tx_state_q)
                T_IDLE: begin
                    if (I2C_XRDY && !tx_empty) begin
                        xrdy_clr_d = 1'b1;
                        tx_state_d = T_PRESENT;
                    end
                end
                T_PRESENT: begin
                    xrdy_clr_d = 1'b0;
                    tx_state_d = T_WAIT;
                end
                T_WAIT: begin
                    if (!I2C_XRDY) tx_state_d = T_IDLE;
                end
                default: tx_state_d = T_IDLE;
            endcase
            case (rx_state_q)
                R_IDLE: begin
                    if (I2C_RRDY && !rx_full) begin
                        rrdy_clr_d = 1'b1;
                        rx_state_d = R_ACK;
                    end
                end
                R_ACK: begin
                    rrdy_clr_d = 1'b0;
                    rx_state_d = R_WAIT;
                end
                R_WAIT: begin
                    if (!I2C_RRDY) rx_state_d = R_IDLE;
                end
                default: rx_state_d = R_IDLE;
            endcase
        end
        if (FLUSH) begin
            tx_state_d = T_IDLE;
            xrdy_clr_d = 1'b0;
            rx_state_d = R_IDLE;
            rrdy_clr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            tx_state_q <= T_IDLE;
            rx_state_q <= R_IDLE;
            xrdy_clr_q <= 1'b0;
            rrdy_clr_q <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            rx_rdata_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            xrdy_clr_q <= xrdy_clr_d;
            rrdy_clr_q <= rrdy_clr_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_rdata_q <= rx_rdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= TX_WDATA;
        if (rx_push) rx_mem_q[rx_wp_q] <= I2C_RxDATA;
    end

`ifdef I2C_HOST_FIFO_IRQ_EN
    logic [1:0] err_q, err_d;
    logic       irq_q, irq_d;

    // A new error in the same cycle as ERR_CLR is kept
    always_comb begin
        err_d = err_q;
        if (ERR_CLR) err_d = '0;
        if (TX_WR && tx_full) err_d[0] = 1'b1;
        if (RX_RD && rx_empty) err_d[1] = 1'b1;
        irq_d = tx_empty | ~rx_empty | I2C_NACK | (|err_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= '0;
            irq_q <= 1'b0;
        end else begin
            err_q <= err_d;
            irq_q <= irq_d;
        end
    end

    assign ERR_FLAGS = err_q;
    assign IRQ       = irq_q;
`else
    logic unused_err_inputs;
    assign unused_err_inputs = ERR_CLR ^ I2C_NACK;
    assign ERR_FLAGS = 2'b00;
    assign IRQ       = 1'b0;
`endif

    assign TX_FULL      = tx_full;
    assign TX_LEVEL     = tx_cnt_q;
    assign RX_RDATA     = rx_rdata_q;
    assign RX_EMPTY     = rx_empty;
    assign RX_LEVEL     = rx_cnt_q;
    assign I2C_CLK      = tick_q;
    assign I2C_TxDATA   = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q];
    assign I2C_XRDY_CLR = xrdy_clr_q;
    assign I2C_RRDY_CLR = rrdy_clr_q;

endmodule

// File: tb/tb_i2c_host_fifo.sv
// Self-checking bench for i2c_host_fifo: divider, TX/RX handshakes,
// FIFO boundaries, FLUSH and mid-handshake reset, with byte scoreboards.
module tb_i2c_host_fifo;

   localparam int DEPTH = 16;
   localparam int LW = $clog2(DEPTH) + 1;
`ifdef I2C_HOST_FIFO_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   logic [15:0] clkDiv;
   logic flush, txWr, rxRd, xrdy, rrdy, nack, errClr;
   logic [7:0] txWdata, rxData;
   logic txFull, rxEmpty, i2cClk, xrdyClr, rrdyClr, irq;
   logic [LW-1:0] txLevel, rxLevel;
   logic [7:0] rxRdata, txData;
   logic [1:0] errFlags;

   int checks = 0;
   int errors = 0;
   logic [7:0] txExp[$];
   logic [7:0] rxExp[$];

   typedef struct {
      logic wr;
      logic [7:0] wdata;
      logic rd;
      logic fl;
      logic eclr;
      int expLevel;
      logic expFull;
      logic [7:0] expHead;
      logic [1:0] expErr;
      logic chkIrq;
      logic expIrq;
   } vec_t;

   vec_t vecs [DEPTH+8];

   i2c_host_fifo #(.DEPTH(DEPTH)) dut (
      .CLK(clock), .RESET(reset), .CLKDIV(clkDiv), .FLUSH(flush),
      .TX_WR(txWr), .TX_WDATA(txWdata), .TX_FULL(txFull), .TX_LEVEL(txLevel),
      .RX_RD(rxRd), .RX_RDATA(rxRdata), .RX_EMPTY(rxEmpty), .RX_LEVEL(rxLevel),
      .I2C_CLK(i2cClk), .I2C_TxDATA(txData), .I2C_XRDY(xrdy), .I2C_XRDY_CLR(xrdyClr),
      .I2C_RxDATA(rxData), .I2C_RRDY(rrdy), .I2C_RRDY_CLR(rrdyClr), .I2C_NACK(nack),
      .ERR_CLR(errClr), .ERR_FLAGS(errFlags), .IRQ(irq)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clock = ~clock;

   // One comparison: counts it, reports a miss with actual and required values
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drive one table row onto the CPU-side inputs
   task automatic applyStimulus(input vec_t v);
      txWr = v.wr;
      txWdata = v.wdata;
      rxRd = v.rd;
      flush = v.fl;
      errClr = v.eclr;
   endtask

   // Wait (bounded) for a CLR output to reach the given level
   task automatic waitClr(input bit rxSide, input bit lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((rxSide ? rrdyClr : xrdyClr) == lvl) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Steps until the next I2C_CLK pulse, returning the number of edges taken
   task automatic measureGap(output int gap);
      gap = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         gap++;
         if (i2cClk) break;
      end
   endtask

   // Count CLR pulses seen over a window of cycles
   task automatic countClr(input bit rxSide, input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (rxSide ? rrdyClr : xrdyClr) seen++;
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_tx_full"}, 32'(txFull), 0);
      checkOutput({tag, "_tx_level"}, 32'(txLevel), 0);
      checkOutput({tag, "_rx_rdata"}, 32'(rxRdata), 0);
      checkOutput({tag, "_rx_empty"}, 32'(rxEmpty), 1);
      checkOutput({tag, "_rx_level"}, 32'(rxLevel), 0);
      checkOutput({tag, "_i2c_clk"}, 32'(i2cClk), 0);
      checkOutput({tag, "_txdata"}, 32'(txData), 0);
      checkOutput({tag, "_xrdy_clr"}, 32'(xrdyClr), 0);
      checkOutput({tag, "_rrdy_clr"}, 32'(rrdyClr), 0);
      checkOutput({tag, "_err"}, 32'(errFlags), 0);
      checkOutput({tag, "_irq"}, 32'(irq), 0);
   endtask

   initial begin
      int gap;
      int seen;
      bit ok;
      logic [7:0] e;

      for (int i = 0; i <= DEPTH; i++) begin
         vecs[i] = '{1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0,
                     (i + 1 >= DEPTH) ? DEPTH : i + 1, (i + 1 >= DEPTH), 8'h40,
                     (IRQ_EN && i == DEPTH) ? 2'b01 : 2'b00, !IRQ_EN, 1'b0};
      end
      vecs[DEPTH+1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, DEPTH, 1'b1, 8'h40,
                        IRQ_EN ? 2'b01 : 2'b00, 1'b1, IRQ_EN};
      vecs[DEPTH+2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, DEPTH, 1'b1, 8'h40, 2'b00, !IRQ_EN, 1'b0};
      vecs[DEPTH+3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 2'b00, !IRQ_EN, 1'b0};
      vecs[DEPTH+4] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h77, 2'b00, !IRQ_EN, 1'b0};
      vecs[DEPTH+5] = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 2'b00, !IRQ_EN, 1'b0};
      vecs[DEPTH+6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00,
                        IRQ_EN ? 2'b10 : 2'b00, !IRQ_EN, 1'b0};
      vecs[DEPTH+7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 2'b00, !IRQ_EN, 1'b0};

      reset = 1'b1; clkDiv = 16'd3; flush = 0; txWr = 0; rxRd = 0; xrdy = 0;
      rrdy = 0; nack = 0; errClr = 0; txWdata = 0; rxData = 0;
      step();
      step();
      checkResetState("reset");

      // Divider: period 4, then CLKDIV lowered to 1 while the counter sits at 2
      reset = 1'b0;
      measureGap(gap);
      checkOutput("div_first_pulse", 32'(gap), 4);
      measureGap(gap);
      checkOutput("div_gap4_a", 32'(gap), 4);
      measureGap(gap);
      checkOutput("div_gap4_b", 32'(gap), 4);
      step();
      step();
      clkDiv = 16'd1;
      measureGap(gap);
      checkOutput("div_lowered_wrap", 32'(gap), 1);
      measureGap(gap);
      checkOutput("div_gap2_a", 32'(gap), 2);
      measureGap(gap);
      checkOutput("div_gap2_b", 32'(gap), 2);
      clkDiv = 16'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("div_zero_every_cycle", 32'(i2cClk), 1);
      end
      clkDiv = 16'd1;

      // TX handshake with scoreboard
      txWr = 1; txWdata = 8'hA5; txExp.push_back(8'hA5); step();
      txWdata = 8'h3C; txExp.push_back(8'h3C); step();
      txWr = 0;
      checkOutput("tx_level_2", 32'(txLevel), 2);
      xrdy = 1;
      waitClr(1'b0, 1'b1, 20, ok);
      checkOutput("tx_clr1_rise", 32'(ok), 1);
      e = (txExp.size() > 0) ? txExp[0] : 8'hxx;
      checkOutput("tx_byte1", 32'(txData), 32'(e));
      gap = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!xrdyClr) break;
         gap++;
         checkOutput("tx_byte1_stable", 32'(txData), 32'(e));
      end
      checkOutput("tx_clr1_width", 32'(gap), 2);
      if (txExp.size() > 0) void'(txExp.pop_front());
      checkOutput("tx_level_1", 32'(txLevel), 1);
      countClr(1'b0, 12, seen);
      checkOutput("tx_no_double_supply", 32'(seen), 0);
      xrdy = 0;
      repeat (6) step();
      xrdy = 1;
      waitClr(1'b0, 1'b1, 20, ok);
      checkOutput("tx_clr2_rise", 32'(ok), 1);
      e = (txExp.size() > 0) ? txExp.pop_front() : 8'hxx;
      checkOutput("tx_byte2", 32'(txData), 32'(e));
      waitClr(1'b0, 1'b0, 20, ok);
      checkOutput("tx_clr2_fall", 32'(ok), 1);
      checkOutput("tx_level_0", 32'(txLevel), 0);
      checkOutput("tx_empty_head", 32'(txData), 0);
      xrdy = 0;
      repeat (4) step();

      // Table: fill past full, error flags, flush priority, empty RX read
      for (int i = 0; i < DEPTH + 8; i++) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput($sformatf("vec%0d_level", i), 32'(txLevel), 32'(vecs[i].expLevel));
         checkOutput($sformatf("vec%0d_full", i), 32'(txFull), 32'(vecs[i].expFull));
         checkOutput($sformatf("vec%0d_head", i), 32'(txData), 32'(vecs[i].expHead));
         checkOutput($sformatf("vec%0d_err", i), 32'(errFlags), 32'(vecs[i].expErr));
         if (vecs[i].chkIrq) checkOutput($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].expIrq));
      end
      txWr = 0; rxRd = 0; flush = 0; errClr = 0;

      // RX: fill to DEPTH, one extra byte stalls until a read frees a slot
      for (int k = 0; k < DEPTH; k++) begin
         rxData = 8'(8'h90 + k);
         rrdy = 1;
         waitClr(1'b1, 1'b1, 20, ok);
         checkOutput($sformatf("rx_clr_rise%0d", k), 32'(ok), 1);
         rxExp.push_back(8'(8'h90 + k));
         rrdy = 0;
         waitClr(1'b1, 1'b0, 20, ok);
         checkOutput($sformatf("rx_clr_fall%0d", k), 32'(ok), 1);
         repeat (5) step();
      end
      checkOutput("rx_level_full", 32'(rxLevel), DEPTH);
      rxData = 8'hA0;
      rrdy = 1;
      countClr(1'b1, 12, seen);
      checkOutput("rx_backpressure", 32'(seen), 0);
      checkOutput("rx_level_stalled", 32'(rxLevel), DEPTH);
      e = (rxExp.size() > 0) ? rxExp.pop_front() : 8'hxx;
      checkOutput("rx_head_first", 32'(rxRdata), 32'(e));
      rxRd = 1; step(); rxRd = 0;
      checkOutput("rx_level_after_pop", 32'(rxLevel), DEPTH - 1);
      waitClr(1'b1, 1'b1, 20, ok);
      checkOutput("rx_stalled_accepted", 32'(ok), 1);
      rxExp.push_back(8'hA0);
      checkOutput("rx_level_refull", 32'(rxLevel), DEPTH);
      rrdy = 0;
      rxRd = 1;
      for (int i = 0; i < DEPTH + 2 && rxExp.size() > 0; i++) begin
         e = rxExp.pop_front();
         checkOutput($sformatf("rx_order%0d", i), 32'(rxRdata), 32'(e));
         step();
      end
      checkOutput("rx_drained_empty", 32'(rxEmpty), 1);
      step();
      rxRd = 0;
      checkOutput("rx_empty_read_holds", 32'(rxRdata), 32'hA0);
      checkOutput("rx_empty_read_level", 32'(rxLevel), 0);
      checkOutput("rx_underflow_flag", 32'(errFlags), IRQ_EN ? 32'h2 : 32'h0);
      errClr = 1; step(); errClr = 0;
      repeat (6) step();

      // FLUSH while the TX FSM presents a byte, with RX holding data
      clkDiv = 16'd3;
      rxData = 8'h55; rrdy = 1;
      waitClr(1'b1, 1'b1, 30, ok);
      checkOutput("fl_rx_clr_rise", 32'(ok), 1);
      rrdy = 0;
      step();
      txWr = 1;
      txWdata = 8'h11; step();
      txWdata = 8'h22; step();
      txWdata = 8'h33; step();
      txWr = 0;
      xrdy = 1;
      waitClr(1'b0, 1'b1, 30, ok);
      checkOutput("fl_tx_present", 32'(ok), 1);
      checkOutput("fl_tx_level3", 32'(txLevel), 3);
      checkOutput("fl_rx_level1", 32'(rxLevel), 1);
      flush = 1; step(); flush = 0;
      checkOutput("fl_xrdy_clr", 32'(xrdyClr), 0);
      checkOutput("fl_tx_level", 32'(txLevel), 0);
      checkOutput("fl_rx_empty", 32'(rxEmpty), 1);
      checkOutput("fl_rrdy_clr", 32'(rrdyClr), 0);
      countClr(1'b0, 10, seen);
      checkOutput("fl_no_supply", 32'(seen), 0);
      xrdy = 0;
      repeat (10) step();

      // Reset in the middle of an RX handshake, then a normal transfer
      rxData = 8'h66; rrdy = 1;
      waitClr(1'b1, 1'b1, 30, ok);
      checkOutput("rst_rx_clr_rise", 32'(ok), 1);
      reset = 1; step();
      checkResetState("midrst");
      reset = 0; rrdy = 0;
      repeat (10) step();
      rxData = 8'h67; rrdy = 1;
      waitClr(1'b1, 1'b1, 30, ok);
      checkOutput("post_rst_clr_rise", 32'(ok), 1);
      rrdy = 0;
      step();
      checkOutput("post_rst_rdata", 32'(rxRdata), 32'h67);
      checkOutput("post_rst_level", 32'(rxLevel), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
